ccl_labeler: RTL and testbench
==============================

CCL_LABELER -- requirements
Module: ccl_labeler

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter LABEL_WIDTH, default 8, label bits; label 0 = background.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  block enable; when low, pixels are ignored and all state holds.
REQ-007 frame_start  input  1  qualifies the current pix_valid beat as pixel (0,0).
REQ-008 pix_valid  input  1  binary motion-mask pixel valid.
REQ-009 pix_fg  input  1  pixel is foreground.
REQ-010 label_valid  output  1  label_out valid.
REQ-011 label_out  output  LABEL_WIDTH  provisional label of the accepted pixel.
REQ-012 merge_valid  output  1  equivalence pulse to the label merger.
REQ-013 merge_a  output  LABEL_WIDTH  smaller label of the equivalent pair.
REQ-014 merge_b  output  LABEL_WIDTH  larger label of the equivalent pair.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-016 num_labels  output  LABEL_WIDTH  count of labels allocated in the finished frame; valid with frame_done.
REQ-017 label_overflow  output  1  sticky flag: label space exhausted in the current frame.

Function
REQ-018 A pixel is accepted when enable=1 and pix_valid=1; all outputs are registered, with a latency of exactly 1 cycle from acceptance.
REQ-019 Column counter x counts 0..IMG_WIDTH-1 and wraps to 0 with y+1; y counts 0..IMG_HEIGHT-1.
REQ-020 frame_start on an accepted beat forces x=0, y=0 for that pixel, sets next_label=1 and clears label_overflow, even mid-frame.
REQ-021 Neighbours use 4-connectivity: L = label at (x-1,y), forced to 0 when x=0; U = label at (x,y-1) from the line buffer, forced to 0 when y=0.
REQ-022 Background pixel -> label 0, no merge.
REQ-023 Foreground with L=U=0 -> label next_label, then next_label increments.
REQ-024 Foreground with exactly one of L,U nonzero -> that label.
REQ-025 Foreground with L=U nonzero -> that label, no merge.
REQ-026 Foreground with L,U nonzero and unequal -> label min(L,U); merge_valid=1, merge_a=min, merge_b=max, in the same cycle as label_valid.
REQ-027 The line buffer entry at column x is written with the output label on every accepted pixel, read-before-write.
REQ-028 Overflow: a new label requested when next_label = 2^LABEL_WIDTH-1 is assigned that value; label_overflow is set; next_label saturates.
REQ-029 Acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1) -> frame_done=1 one cycle later with num_labels = next_label-1 (saturated value on overflow); counters then return to (0,0).
REQ-030 merge_valid, label_valid and frame_done are single-cycle pulses; they are low when no pixel is accepted.
REQ-031 enable low mid-line holds x, y, L, next_label and the line buffer; processing resumes unchanged.

Reset
REQ-032 While rst=0: all outputs 0, x=y=0, L=0, next_label=1, label_overflow=0.
REQ-033 Line buffer contents are not reset; the y=0 masking of REQ-021 makes them don't-care.
REQ-034 Reset asserted mid-frame aborts the frame with no frame_done pulse; the first accepted pixel after release is (0,0).

Structure
REQ-035 LABEL_WIDTH, the label typedef and the LABEL_BG=0 constant belong in shared package lm_pkg, together with the label merger interface.
REQ-036 The line buffer is sub-module lm_line_buf: IMG_WIDTH x LABEL_WIDTH, 1 read plus 1 write at the same address per cycle.

Verification
REQ-037 4x3 frame, single isolated fg pixel at (1,1) -> label 1; frame_done with num_labels=1; no merge.
REQ-038 U-shape: fg columns 0 and 3 in rows 0-1, row 2 all fg -> row 2 x=3 gives L=1, U=2 -> merge_valid, merge_a=1, merge_b=2; num_labels=2.
REQ-039 LABEL_WIDTH=2, four isolated pixels -> labels 1,2,3,3; label_overflow=1; num_labels=3.
REQ-040 Fg at x=IMG_WIDTH-1 of row 0 and at x=0 of row 1 -> distinct labels 1 and 2 (no left wrap across lines); no merge.
REQ-041 enable low for 5 cycles mid-line with pix_valid high -> identical labels to the uninterrupted run; no pulses during the gap.
REQ-042 frame_start at pixel (2,1) of a partial frame, then rst low for 1 cycle mid-frame -> next_label restarts at 1, overflow cleared, no frame_done, first label after release is 1.

Source files
------------

// File: rtl/lm_pkg.sv
// Shared label-merger definitions for the connected-component labeler.
// Holds the default label width, the label type, the background label
// constant and the equivalence-pair record passed to the label merger.
// No ports.
package lm_pkg;

  // Default label width; label 0 is reserved for background.
  localparam int LABEL_WIDTH = 8;

  typedef logic [LABEL_WIDTH-1:0] label_t;

  localparam label_t LABEL_BG = '0;

  // One equivalence report towards the label merger: a is the smaller label,
  // b the larger one.
  typedef struct packed {
    logic   valid;
    label_t a;
    label_t b;
  } merge_t;

endpackage

// File: rtl/ccl_labeler_if.sv
// Pixel-stream / label-stream bundle of the connected-component labeler.
// Ports: none (plain interface). Signals:
//   enable, frame_start, pix_valid, pix_fg           : pixel side, into the labeler
//   label_valid, label_out                           : provisional label per pixel
//   merge_valid, merge_a, merge_b                    : equivalence pair to the merger
//   frame_done, num_labels, label_overflow           : frame status
// Modports: slave = labeler side, master = pixel source / label sink side.
interface ccl_labeler_if #(
  parameter int LABEL_WIDTH = lm_pkg::LABEL_WIDTH
);

  logic                   enable;
  logic                   frame_start;
  logic                   pix_valid;
  logic                   pix_fg;
  logic                   label_valid;
  logic [LABEL_WIDTH-1:0] label_out;
  logic                   merge_valid;
  logic [LABEL_WIDTH-1:0] merge_a;
  logic [LABEL_WIDTH-1:0] merge_b;
  logic                   frame_done;
  logic [LABEL_WIDTH-1:0] num_labels;
  logic                   label_overflow;

  modport slave (
    input  enable, frame_start, pix_valid, pix_fg,
    output label_valid, label_out, merge_valid, merge_a, merge_b,
           frame_done, num_labels, label_overflow
  );

  modport master (
    output enable, frame_start, pix_valid, pix_fg,
    input  label_valid, label_out, merge_valid, merge_a, merge_b,
           frame_done, num_labels, label_overflow
  );

endinterface

// File: rtl/lm_line_buf.sv
// One-line label buffer for the labeler: DEPTH entries of WIDTH bits,
// one asynchronous read and one write per cycle at the same address.
// The read returns the old contents (read-before-write) because the write
// only lands on the clock edge. Contents are deliberately not reset.
// Ports:
//   clk      : clock
//   wr_en_i  : write strobe
//   addr_i   : shared read/write address (column)
//   wdata_i  : label to store
//   rdata_o  : label currently stored at addr_i
module lm_line_buf #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; no reset because row 0 never looks at the buffer.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ccl_labeler.sv
// Streaming first-pass connected-component labeler (4-connectivity).
// Every accepted binary pixel gets a provisional label one cycle later;
// when the left and upper neighbours carry different labels the pair is
// reported to the label merger in the same cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : ccl_labeler_if.slave (pixel input, label/merge/frame outputs)
module ccl_labeler
  import lm_pkg::*;
#(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int LABEL_WIDTH = lm_pkg::LABEL_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  ccl_labeler_if.slave bus
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [LABEL_WIDTH-1:0] LBL_ZERO = LABEL_WIDTH'(LABEL_BG);
  localparam logic [LABEL_WIDTH-1:0] LBL_ONE  = LABEL_WIDTH'(1);
  localparam logic [LABEL_WIDTH-1:0] LBL_MAX  = {LABEL_WIDTH{1'b1}};
  localparam logic [XW-1:0]          X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]          Y_LAST   = YW'(IMG_HEIGHT - 1);

  // Position, neighbour and allocation state.
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [LABEL_WIDTH-1:0] l_q, l_d;
  logic [LABEL_WIDTH-1:0] next_label_q, next_label_d;
  logic                   overflow_q, overflow_d;

  // Registered outputs.
  logic                   label_valid_q, label_valid_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d;
  logic                   merge_valid_q, merge_valid_d;
  logic [LABEL_WIDTH-1:0] merge_a_q, merge_a_d;
  logic [LABEL_WIDTH-1:0] merge_b_q, merge_b_d;
  logic                   frame_done_q, frame_done_d;
  logic [LABEL_WIDTH-1:0] num_labels_q, num_labels_d;

  // Combinational working signals.
  logic                   accept_s;
  logic [XW-1:0]          cur_x_s;
  logic [YW-1:0]          cur_y_s;
  logic [LABEL_WIDTH-1:0] base_next_s;
  logic                   base_ovf_s;
  logic [LABEL_WIDTH-1:0] lb_rdata_s;
  logic [LABEL_WIDTH-1:0] left_s;
  logic [LABEL_WIDTH-1:0] up_s;
  logic [LABEL_WIDTH-1:0] lbl_s;
  logic                   mrg_s;
  logic [LABEL_WIDTH-1:0] mrg_a_s;
  logic [LABEL_WIDTH-1:0] mrg_b_s;
  logic [LABEL_WIDTH-1:0] nl_after_s;
  logic                   ovf_after_s;
  logic                   last_s;

  // Effective position and allocator state of this beat; frame_start restarts
  // the frame on this very pixel, so it overrides the stored state here.
  always_comb begin
    accept_s = bus.enable & bus.pix_valid;
    if (bus.frame_start) begin
      cur_x_s     = '0;
      cur_y_s     = '0;
      base_next_s = LBL_ONE;
      base_ovf_s  = 1'b0;
    end else begin
      cur_x_s     = x_q;
      cur_y_s     = y_q;
      base_next_s = next_label_q;
      base_ovf_s  = overflow_q;
    end
    last_s = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
  end

  lm_line_buf #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (LABEL_WIDTH),
    .AW    (XW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en_i (accept_s),
    .addr_i  (cur_x_s),
    .wdata_i (lbl_s),
    .rdata_o (lb_rdata_s)
  );

  // Neighbour masking: no left wrap across lines, no upper row above row 0.
  always_comb begin
    if (cur_x_s == '0) begin
      left_s = LBL_ZERO;
    end else begin
      left_s = l_q;
    end
    if (cur_y_s == '0) begin
      up_s = LBL_ZERO;
    end else begin
      up_s = lb_rdata_s;
    end
  end

  // Label decision and new-label allocation for the current pixel.
  always_comb begin
    lbl_s       = LBL_ZERO;
    mrg_s       = 1'b0;
    mrg_a_s     = LBL_ZERO;
    mrg_b_s     = LBL_ZERO;
    nl_after_s  = base_next_s;
    ovf_after_s = base_ovf_s;
    if (!bus.pix_fg) begin
      lbl_s = LBL_ZERO;
    end else if ((left_s == LBL_ZERO) && (up_s == LBL_ZERO)) begin
      lbl_s = base_next_s;
      // The last label value is handed out repeatedly once reached.
      if (base_next_s == LBL_MAX) begin
        ovf_after_s = 1'b1;
      end else begin
        nl_after_s = base_next_s + LBL_ONE;
      end
    end else if (left_s == LBL_ZERO) begin
      lbl_s = up_s;
    end else if ((up_s == LBL_ZERO) || (up_s == left_s)) begin
      lbl_s = left_s;
    end else begin
      mrg_s = 1'b1;
      if (left_s < up_s) begin
        mrg_a_s = left_s;
        mrg_b_s = up_s;
      end else begin
        mrg_a_s = up_s;
        mrg_b_s = left_s;
      end
      lbl_s = mrg_a_s;
    end
  end

  // Next-state: state only moves on accepted pixels; output pulses drop otherwise.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    l_d           = l_q;
    next_label_d  = next_label_q;
    overflow_d    = overflow_q;
    label_valid_d = 1'b0;
    label_d       = LBL_ZERO;
    merge_valid_d = 1'b0;
    merge_a_d     = LBL_ZERO;
    merge_b_d     = LBL_ZERO;
    frame_done_d  = 1'b0;
    num_labels_d  = LBL_ZERO;
    if (accept_s) begin
      label_valid_d = 1'b1;
      label_d       = lbl_s;
      merge_valid_d = mrg_s;
      merge_a_d     = mrg_a_s;
      merge_b_d     = mrg_b_s;
      l_d           = lbl_s;
      next_label_d  = nl_after_s;
      overflow_d    = ovf_after_s;
      if (last_s) begin
        x_d          = '0;
        y_d          = '0;
        frame_done_d = 1'b1;
        num_labels_d = ovf_after_s ? LBL_MAX : (nl_after_s - LBL_ONE);
      end else if (cur_x_s == X_LAST) begin
        x_d = '0;
        y_d = cur_y_s + YW'(1);
      end else begin
        x_d = cur_x_s + XW'(1);
        y_d = cur_y_s;
      end
    end else begin
      label_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q           <= '0;
      y_q           <= '0;
      l_q           <= LBL_ZERO;
      next_label_q  <= LBL_ONE;
      overflow_q    <= 1'b0;
      label_valid_q <= 1'b0;
      label_q       <= LBL_ZERO;
      merge_valid_q <= 1'b0;
      merge_a_q     <= LBL_ZERO;
      merge_b_q     <= LBL_ZERO;
      frame_done_q  <= 1'b0;
      num_labels_q  <= LBL_ZERO;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      l_q           <= l_d;
      next_label_q  <= next_label_d;
      overflow_q    <= overflow_d;
      label_valid_q <= label_valid_d;
      label_q       <= label_d;
      merge_valid_q <= merge_valid_d;
      merge_a_q     <= merge_a_d;
      merge_b_q     <= merge_b_d;
      frame_done_q  <= frame_done_d;
      num_labels_q  <= num_labels_d;
    end
  end

  assign bus.label_valid    = label_valid_q;
  assign bus.label_out      = label_q;
  assign bus.merge_valid    = merge_valid_q;
  assign bus.merge_a        = merge_a_q;
  assign bus.merge_b        = merge_b_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.num_labels     = num_labels_q;
  assign bus.label_overflow = overflow_q;

endmodule

// File: tb/tb_ccl_labeler.sv
// Scoreboard bench for ccl_labeler on a 4x3 image: one instance with 8-bit
// labels and one with 2-bit labels for the label-space exhaustion case.
module tb_ccl_labeler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ccl_labeler_if #(.LABEL_WIDTH(8)) bus8 ();
  ccl_labeler_if #(.LABEL_WIDTH(2)) bus2 ();

  ccl_labeler #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .LABEL_WIDTH(8)) dut8 (
    .clk (clk), .rst (rst_n), .bus (bus8)
  );
  ccl_labeler #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .LABEL_WIDTH(2)) dut2 (
    .clk (clk), .rst (rst_n), .bus (bus2)
  );

  typedef struct { int lab; bit m; int ma; int mb; int cyc; } exp_t;
  typedef struct { int num; int ovf; } fd_t;
  typedef int lab_arr_t [12];

  exp_t q8[$];
  exp_t q2[$];
  fd_t  fd8[$];
  fd_t  fd2[$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops expectations whenever an instance presents a pulse.
  task automatic mon(input int sel, input logic lv, input int lo, input logic mv,
                     input int ma, input int mb, input logic fd, input int nl,
                     input logic ov);
    exp_t e;
    fd_t  f;
    bit   have;
    if (lv) begin
      have = (sel == 8) ? (q8.size() > 0) : (q2.size() > 0);
      if (!have) chk($sformatf("d%0d_unexpected_label", sel), 1, 0);
      else begin
        e = (sel == 8) ? q8.pop_front() : q2.pop_front();
        chk($sformatf("d%0d_label", sel), lo, e.lab);
        chk($sformatf("d%0d_merge_valid", sel), mv, e.m);
        if (e.m) begin
          chk($sformatf("d%0d_merge_a", sel), ma, e.ma);
          chk($sformatf("d%0d_merge_b", sel), mb, e.mb);
        end
        chk($sformatf("d%0d_latency", sel), cyc, e.cyc + 1);
      end
    end else if (mv) begin
      chk($sformatf("d%0d_merge_without_label", sel), 1, 0);
    end
    if (fd) begin
      have = (sel == 8) ? (fd8.size() > 0) : (fd2.size() > 0);
      if (!have) chk($sformatf("d%0d_unexpected_frame_done", sel), 1, 0);
      else begin
        f = (sel == 8) ? fd8.pop_front() : fd2.pop_front();
        chk($sformatf("d%0d_num_labels", sel), nl, f.num);
        chk($sformatf("d%0d_overflow_at_done", sel), ov, f.ovf);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(8, bus8.label_valid, int'(bus8.label_out), bus8.merge_valid, int'(bus8.merge_a),
        int'(bus8.merge_b), bus8.frame_done, int'(bus8.num_labels), bus8.label_overflow);
    mon(2, bus2.label_valid, int'(bus2.label_out), bus2.merge_valid, int'(bus2.merge_a),
        int'(bus2.merge_b), bus2.frame_done, int'(bus2.num_labels), bus2.label_overflow);
  end

  // One accepted pixel; called just after a rising edge, returns just after the next.
  task automatic beat(input int sel, input logic fs, input logic fg, input int lab,
                      input bit m, input int ma, input int mb,
                      input bit last, input int num, input int ovf);
    exp_t e;
    fd_t  f;
    e.lab = lab; e.m = m; e.ma = ma; e.mb = mb; e.cyc = cyc;
    f.num = num; f.ovf = ovf;
    if (sel == 8) begin
      q8.push_back(e);
      if (last) fd8.push_back(f);
      bus8.pix_valid = 1'b1; bus8.frame_start = fs; bus8.pix_fg = fg;
    end else begin
      q2.push_back(e);
      if (last) fd2.push_back(f);
      bus2.pix_valid = 1'b1; bus2.frame_start = fs; bus2.pix_fg = fg;
    end
    @(posedge clk); #1;
    if (sel == 8) begin
      bus8.pix_valid = 1'b0; bus8.frame_start = 1'b0; bus8.pix_fg = 1'b0;
    end else begin
      bus2.pix_valid = 1'b0; bus2.frame_start = 1'b0; bus2.pix_fg = 1'b0;
    end
  endtask

  // Five cycles of enable low with valid foreground pixels offered on bus8.
  task automatic do_gap();
    bus8.enable = 1'b0; bus8.pix_valid = 1'b1; bus8.pix_fg = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("gap_label_valid", bus8.label_valid, 0);
      chk("gap_merge_valid", bus8.merge_valid, 0);
      chk("gap_frame_done", bus8.frame_done, 0);
    end
    bus8.enable = 1'b1; bus8.pix_valid = 1'b0; bus8.pix_fg = 1'b0;
  endtask

  task automatic run_frame(input int sel, input bit use_fs, input logic [11:0] fg,
                           input lab_arr_t lab, input int m_idx, input int ma,
                           input int mb, input int num, input int ovf, input int gap_at);
    for (int i = 0; i < 12; i++) begin
      if (i == gap_at && sel == 8) do_gap();
      beat(sel, use_fs && (i == 0), fg[i], lab[i], (i == m_idx), ma, mb,
           (i == 11), num, ovf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.enable = 1'b1; bus8.pix_valid = 1'b0; bus8.frame_start = 1'b0; bus8.pix_fg = 1'b0;
    bus2.enable = 1'b1; bus2.pix_valid = 1'b0; bus2.frame_start = 1'b0; bus2.pix_fg = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_label_valid", bus8.label_valid, 0);
    chk("rst_label_out", bus8.label_out, 0);
    chk("rst_merge_valid", bus8.merge_valid, 0);
    chk("rst_merge_a", bus8.merge_a, 0);
    chk("rst_merge_b", bus8.merge_b, 0);
    chk("rst_frame_done", bus8.frame_done, 0);
    chk("rst_num_labels", bus8.num_labels, 0);
    chk("rst_overflow", bus8.label_overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Isolated pixel at (1,1).
    run_frame(8, 1, 12'h020, lab_arr_t'{0,0,0,0, 0,1,0,0, 0,0,0,0}, -1, 0, 0, 1, 0, -1);
    // U-shape: merge 1/2 at the last pixel.
    run_frame(8, 1, 12'hF99, lab_arr_t'{1,0,0,2, 1,0,0,2, 1,1,1,1}, 11, 1, 2, 2, 0, -1);
    // Same U-shape with an enable gap before pixel (2,2).
    run_frame(8, 1, 12'hF99, lab_arr_t'{1,0,0,2, 1,0,0,2, 1,1,1,1}, 11, 1, 2, 2, 0, 10);
    // End of row 0 and start of row 1 are not neighbours.
    run_frame(8, 1, 12'h018, lab_arr_t'{0,0,0,1, 2,0,0,0, 0,0,0,0}, -1, 0, 0, 2, 0, -1);

    // 2-bit labels: normal frame, then label-space exhaustion.
    run_frame(2, 1, 12'h020, lab_arr_t'{0,0,0,0, 0,1,0,0, 0,0,0,0}, -1, 0, 0, 1, 0, -1);
    run_frame(2, 1, 12'h505, lab_arr_t'{1,0,2,0, 0,0,0,0, 3,0,3,0}, -1, 0, 0, 3, 1, -1);

    // Partial frame restarted by frame_start at (2,1), then reset mid-frame.
    beat(8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    beat(8, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) beat(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    beat(8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    beat(8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    beat(8, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_label_valid", bus8.label_valid, 0);
    chk("midrst_label_out", bus8.label_out, 0);
    chk("midrst_overflow_d2", bus2.label_overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // No frame_start: the first pixel after release must be (0,0), labels restart at 1.
    run_frame(8, 0, 12'h020, lab_arr_t'{0,0,0,0, 0,1,0,0, 0,0,0,0}, -1, 0, 0, 1, 0, -1);
    run_frame(2, 0, 12'h020, lab_arr_t'{0,0,0,0, 0,1,0,0, 0,0,0,0}, -1, 0, 0, 1, 0, -1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_q8", q8.size(), 0);
    chk("drain_q2", q2.size(), 0);
    chk("drain_fd8", fd8.size(), 0);
    chk("drain_fd2", fd2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
